// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared constants and types for the RV32I writeback stage
//
// Purpose: result-source selects, load funct3 codes and the writeback FSM
// state type, shared by wb_stage, its interface and load_ext.
// Ports: none (package).

package wb_stage_pkg;

  localparam int XLEN = 32;

  // Result source select carried from MEM into WB. Code 3 is reserved and
  // behaves exactly like ALU.
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  // RV32I load funct3 encodings. Anything else is treated as LW.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_READY     = 2'd2
  } wb_state_e;

  function automatic logic is_load(input logic [1:0] wb_sel);
    return wb_sel == WB_SEL_LOAD;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM/WB handshake, data-memory response and rf write bundle
//
// Purpose: groups every non-clock/reset signal of wb_stage.
// Ports (signals):
//   i_valid/o_ready           MEM -> WB handshake
//   i_rd_wen, i_rd_waddr      destination register of the offered instruction
//   i_wb_sel                  result source (ALU / LOAD / PC4 / reserved)
//   i_alu_result, i_pc_plus4  candidate results
//   i_load_funct3, i_addr_lo  load type and effective address bits [1:0]
//   i_dmem_rvalid/i_dmem_rdata data-memory read response
//   o_rd_wen/o_rd_waddr/o_rd_wdata register file write port
//   o_retire                  one-cycle pulse per retired instruction
//   o_load_pending            held entry is a load awaiting data
//   o_pending_rd              rd of the held entry
// Modports: master = upstream/environment side, slave = wb_stage.

interface wb_stage_if;
  import wb_stage_pkg::*;

  logic             i_valid;
  logic             o_ready;
  logic             i_rd_wen;
  logic [4:0]       i_rd_waddr;
  logic [1:0]       i_wb_sel;
  logic [XLEN-1:0]  i_alu_result;
  logic [XLEN-1:0]  i_pc_plus4;
  logic [2:0]       i_load_funct3;
  logic [1:0]       i_addr_lo;
  logic             i_dmem_rvalid;
  logic [XLEN-1:0]  i_dmem_rdata;
  logic             o_rd_wen;
  logic [4:0]       o_rd_waddr;
  logic [XLEN-1:0]  o_rd_wdata;
  logic             o_retire;
  logic             o_load_pending;
  logic [4:0]       o_pending_rd;

  modport master (
    output i_valid, i_rd_wen, i_rd_waddr, i_wb_sel, i_alu_result, i_pc_plus4,
           i_load_funct3, i_addr_lo, i_dmem_rvalid, i_dmem_rdata,
    input  o_ready, o_rd_wen, o_rd_waddr, o_rd_wdata, o_retire,
           o_load_pending, o_pending_rd
  );

  modport slave (
    input  i_valid, i_rd_wen, i_rd_waddr, i_wb_sel, i_alu_result, i_pc_plus4,
           i_load_funct3, i_addr_lo, i_dmem_rvalid, i_dmem_rdata,
    output o_ready, o_rd_wen, o_rd_waddr, o_rd_wdata, o_retire,
           o_load_pending, o_pending_rd
  );

endinterface

// File: rtl/load_ext.sv
// rtl/load_ext.sv - RV32I load byte/half extraction and sign/zero extension
//
// Purpose: turns a raw aligned memory word into the architectural load value.
// Ports:
//   rdata   in  32  raw aligned word from data memory
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU, others behave as LW)
//   addr_lo in  2   effective address bits [1:0]
//   data    out 32  extended load result

module load_ext
  import wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Halfword loads only look at bit 1; a misaligned bit 0 is ignored.
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage driving the register file write port
//
// Purpose: holds one MEM/WB entry, waits for variable-latency load data,
// extends loads and presents a registered rf write plus a retire pulse.
// Ports:
//   i_clk  in  clock
//   i_rst  in  synchronous active-high reset
//   bus    wb_stage_if.slave (handshake, results, dmem response, rf write,
//          retire, load-pending/pending-rd hazard info)

module wb_stage
  import wb_stage_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  wb_stage_if.slave bus
);

  wb_state_e       state;
  logic            entry_wen;
  logic [4:0]      entry_rd;
  logic [2:0]      entry_funct3;
  logic [1:0]      entry_addr_lo;
  logic [XLEN-1:0] entry_data;

  logic            rf_wen_q;
  logic            retire_q;
  logic            load_pending_q;

  logic            accept;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] direct_result;

  // Only a load still waiting for memory blocks the upstream stage; a READY
  // entry is written this cycle, so a new instruction may replace it.
  assign bus.o_ready = (state != ST_WAIT_LOAD);
  assign accept      = bus.i_valid && bus.o_ready;

  assign direct_result = (bus.i_wb_sel == WB_SEL_PC4) ? bus.i_pc_plus4
                                                      : bus.i_alu_result;

  // Extraction uses the funct3/addr_lo captured with the load, since the
  // upstream inputs have moved on by the time data returns.
  load_ext u_load_ext (
    .rdata   (bus.i_dmem_rdata),
    .funct3  (entry_funct3),
    .addr_lo (entry_addr_lo),
    .data    (load_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= ST_EMPTY;
      entry_wen      <= 1'b0;
      entry_rd       <= 5'd0;
      entry_funct3   <= 3'd0;
      entry_addr_lo  <= 2'd0;
      entry_data     <= '0;
      rf_wen_q       <= 1'b0;
      retire_q       <= 1'b0;
      load_pending_q <= 1'b0;
    end else if (accept) begin
      entry_wen     <= bus.i_rd_wen;
      entry_rd      <= bus.i_rd_waddr;
      entry_funct3  <= bus.i_load_funct3;
      entry_addr_lo <= bus.i_addr_lo;
      if (is_load(bus.i_wb_sel)) begin
        state          <= ST_WAIT_LOAD;
        rf_wen_q       <= 1'b0;
        retire_q       <= 1'b0;
        load_pending_q <= 1'b1;
      end else begin
        state          <= ST_READY;
        entry_data     <= direct_result;
        rf_wen_q       <= bus.i_rd_wen && (bus.i_rd_waddr != 5'd0);
        retire_q       <= 1'b1;
        load_pending_q <= 1'b0;
      end
    end else begin
      case (state)
        ST_WAIT_LOAD: begin
          if (bus.i_dmem_rvalid) begin
            state          <= ST_READY;
            entry_data     <= load_data;
            rf_wen_q       <= entry_wen && (entry_rd != 5'd0);
            retire_q       <= 1'b1;
            load_pending_q <= 1'b0;
          end
        end
        ST_READY: begin
          state    <= ST_EMPTY;
          rf_wen_q <= 1'b0;
          retire_q <= 1'b0;
        end
        default: begin
          state    <= ST_EMPTY;
          rf_wen_q <= 1'b0;
          retire_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_rd_wen       = rf_wen_q;
  assign bus.o_rd_waddr     = entry_rd;
  assign bus.o_rd_wdata     = entry_data;
  assign bus.o_retire       = retire_q;
  assign bus.o_load_pending = load_pending_q;
  assign bus.o_pending_rd   = entry_rd;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage

module tb_wb_stage;
  import wb_stage_pkg::*;

  logic i_clk;
  logic i_rst;
  int   tests;
  int   fails;

  wb_stage_if bus ();

  wb_stage dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference: architectural load value from plain shifts and arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] raw);
    logic [31:0] b;
    logic [31:0] h;
    b = (raw >> (8 * int'(lo))) & 32'hFF;
    h = (raw >> (16 * int'(lo[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] model_result(input logic [1:0] sel, input logic [31:0] alu,
                                               input logic [31:0] pc4);
    return (sel == 2'd2) ? pc4 : alu;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
  endtask

  task automatic drive_op(input logic [1:0] sel, input logic wen, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] pc4,
                          input logic [2:0] f3, input logic [1:0] lo);
    bus.i_valid       = 1'b1;
    bus.i_wb_sel      = sel;
    bus.i_rd_wen      = wen;
    bus.i_rd_waddr    = rd;
    bus.i_alu_result  = alu;
    bus.i_pc_plus4    = pc4;
    bus.i_load_funct3 = f3;
    bus.i_addr_lo     = lo;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    idle();
    bus.i_dmem_rvalid = 1'b0;
    bus.i_dmem_rdata  = '0;
    drive_op(2'd0, 1'b0, 5'd0, '0, '0, 3'd0, 2'd0);
    idle();
    tick();
    tick();
    i_rst = 1'b0;
    tests++;
    if ({bus.o_rd_wen, bus.o_retire, bus.o_load_pending} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl got wen/ret/pend=%b exp 000",
               {bus.o_rd_wen, bus.o_retire, bus.o_load_pending});
    end
    tests++;
    if (bus.o_rd_waddr !== 5'd0 || bus.o_rd_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_data got waddr=%0d wdata=%h exp 0/0", bus.o_rd_waddr, bus.o_rd_wdata);
    end
    tests++;
    if (bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b exp 1", bus.o_ready);
    end
  endtask

  task automatic test_alu();
    drive_op(WB_SEL_ALU, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 3'd0, 2'd0);
    tick();
    idle();
    tests++;
    if (bus.o_rd_wen !== 1'b1 || bus.o_rd_waddr !== 5'd5 || bus.o_rd_wdata !== 32'hDEADBEEF
        || bus.o_retire !== 1'b1) begin
      fails++;
      $display("FAIL alu_write got wen=%b waddr=%0d wdata=%h ret=%b exp 1/5/deadbeef/1",
               bus.o_rd_wen, bus.o_rd_waddr, bus.o_rd_wdata, bus.o_retire);
    end
    tick();
    tests++;
    if (bus.o_rd_wen !== 1'b0 || bus.o_retire !== 1'b0) begin
      fails++;
      $display("FAIL alu_empty got wen=%b ret=%b exp 0/0", bus.o_rd_wen, bus.o_retire);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      drive_op(WB_SEL_ALU, 1'b1, 5'(i), 32'h1000 + 32'(i), 32'h0, 3'd0, 2'd0);
      tick();
      tests++;
      if (bus.o_ready !== 1'b1 || bus.o_rd_wen !== 1'b1 || bus.o_rd_waddr !== 5'(i)
          || bus.o_rd_wdata !== 32'h1000 + 32'(i)) begin
        fails++;
        $display("FAIL b2b_%0d got rdy=%b wen=%b waddr=%0d wdata=%h exp 1/1/%0d/%h", i,
                 bus.o_ready, bus.o_rd_wen, bus.o_rd_waddr, bus.o_rd_wdata, i, 32'h1000 + 32'(i));
      end
    end
    idle();
    tick();
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [4] = '{F3_LB, F3_LBU, F3_LHU, F3_LH};
    logic [1:0]  los  [4] = '{2'd3, 2'd3, 2'd2, 2'd1};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'h00001234};
    for (int i = 0; i < 4; i++) begin
      drive_op(WB_SEL_LOAD, 1'b1, 5'd7, 32'hBAD0BAD0, 32'h0, f3s[i], los[i]);
      tick();
      idle();
      bus.i_load_funct3 = 3'd2;
      bus.i_addr_lo     = 2'd0;
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (bus.o_ready !== 1'b0 || bus.o_load_pending !== 1'b1 || bus.o_pending_rd !== 5'd7
            || bus.o_retire !== 1'b0 || bus.o_rd_wen !== 1'b0) begin
          fails++;
          $display("FAIL load%0d_wait%0d got rdy=%b pend=%b prd=%0d ret=%b wen=%b exp 0/1/7/0/0",
                   i, k, bus.o_ready, bus.o_load_pending, bus.o_pending_rd, bus.o_retire, bus.o_rd_wen);
        end
        if (k == 2) begin
          bus.i_dmem_rvalid = 1'b1;
          bus.i_dmem_rdata  = 32'h80FF_1234;
        end
        tick();
      end
      bus.i_dmem_rvalid = 1'b0;
      tests++;
      if (bus.o_rd_wen !== 1'b1 || bus.o_retire !== 1'b1 || bus.o_rd_wdata !== exps[i]
          || bus.o_load_pending !== 1'b0) begin
        fails++;
        $display("FAIL load%0d_data got wen=%b ret=%b wdata=%h pend=%b exp 1/1/%h/0", i,
                 bus.o_rd_wen, bus.o_retire, bus.o_rd_wdata, bus.o_load_pending, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_jal_rd0();
    drive_op(WB_SEL_PC4, 1'b1, 5'd1, 32'h5555_5555, 32'h104, 3'd0, 2'd0);
    tick();
    tests++;
    if (bus.o_rd_wen !== 1'b1 || bus.o_rd_waddr !== 5'd1 || bus.o_rd_wdata !== 32'h104) begin
      fails++;
      $display("FAIL jal got wen=%b waddr=%0d wdata=%h exp 1/1/104",
               bus.o_rd_wen, bus.o_rd_waddr, bus.o_rd_wdata);
    end
    drive_op(WB_SEL_ALU, 1'b1, 5'd0, 32'h1234_5678, 32'h0, 3'd0, 2'd0);
    tick();
    tests++;
    if (bus.o_retire !== 1'b1 || bus.o_rd_wen !== 1'b0) begin
      fails++;
      $display("FAIL rd0 got ret=%b wen=%b exp 1/0", bus.o_retire, bus.o_rd_wen);
    end
    drive_op(2'd3, 1'b1, 5'd9, 32'hA5A5_0001, 32'hFFFF_0000, 3'd0, 2'd0);
    tick();
    idle();
    tests++;
    if (bus.o_rd_wen !== 1'b1 || bus.o_rd_wdata !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL sel_reserved got wen=%b wdata=%h exp 1/a5a50001", bus.o_rd_wen, bus.o_rd_wdata);
    end
    tick();
  endtask

  task automatic test_reset_wait();
    drive_op(WB_SEL_LOAD, 1'b1, 5'd12, 32'h0, 32'h0, F3_LW, 2'd0);
    tick();
    idle();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    bus.i_dmem_rvalid = 1'b1;
    bus.i_dmem_rdata  = 32'hCAFEF00D;
    tick();
    bus.i_dmem_rvalid = 1'b0;
    tests++;
    if (bus.o_rd_wen !== 1'b0 || bus.o_retire !== 1'b0 || bus.o_ready !== 1'b1
        || bus.o_load_pending !== 1'b0) begin
      fails++;
      $display("FAIL rst_wait got wen=%b ret=%b rdy=%b pend=%b exp 0/0/1/0",
               bus.o_rd_wen, bus.o_retire, bus.o_ready, bus.o_load_pending);
    end
    bus.i_dmem_rvalid = 1'b1;
    tick();
    bus.i_dmem_rvalid = 1'b0;
    tick();
    tests++;
    if (bus.o_rd_wen !== 1'b0 || bus.o_retire !== 1'b0 || bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL stray_rvalid got wen=%b ret=%b rdy=%b exp 0/0/1",
               bus.o_rd_wen, bus.o_retire, bus.o_ready);
    end
  endtask

  task automatic test_random();
    logic [1:0]  sel;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] alu, pc4, raw, exp;
    logic [2:0]  f3;
    logic [1:0]  lo;
    int          delay;
    for (int n = 0; n < 80; n++) begin
      sel = 2'($urandom_range(0, 3));
      wen = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      alu = $urandom();
      pc4 = $urandom();
      f3  = 3'($urandom_range(0, 7));
      lo  = 2'($urandom_range(0, 3));
      drive_op(sel, wen, rd, alu, pc4, f3, lo);
      tick();
      if (sel == 2'd1) begin
        idle();
        bus.i_load_funct3 = 3'($urandom_range(0, 7));
        bus.i_addr_lo     = 2'($urandom_range(0, 3));
        delay = $urandom_range(1, 4);
        raw   = $urandom();
        for (int k = 0; k < delay; k++) begin
          tests++;
          if (bus.o_ready !== 1'b0 || bus.o_load_pending !== 1'b1 || bus.o_pending_rd !== rd
              || bus.o_retire !== 1'b0) begin
            fails++;
            $display("FAIL rnd%0d_wait got rdy=%b pend=%b prd=%0d ret=%b exp 0/1/%0d/0", n,
                     bus.o_ready, bus.o_load_pending, bus.o_pending_rd, bus.o_retire, rd);
          end
          if (k == delay - 1) begin
            bus.i_dmem_rvalid = 1'b1;
            bus.i_dmem_rdata  = raw;
          end
          tick();
        end
        bus.i_dmem_rvalid = 1'b0;
        exp = model_load(f3, lo, raw);
      end else begin
        exp = model_result(sel, alu, pc4);
      end
      tests++;
      if (bus.o_retire !== 1'b1 || bus.o_rd_wen !== (wen && rd != 5'd0)
          || bus.o_rd_waddr !== rd || bus.o_rd_wdata !== exp) begin
        fails++;
        $display("FAIL rnd%0d_write sel=%0d f3=%0d got ret=%b wen=%b waddr=%0d wdata=%h exp 1/%b/%0d/%h",
                 n, sel, f3, bus.o_retire, bus.o_rd_wen, bus.o_rd_waddr, bus.o_rd_wdata,
                 wen && rd != 5'd0, rd, exp);
      end
      if ($urandom_range(0, 2) == 0) begin
        idle();
        tick();
        tests++;
        if (bus.o_retire !== 1'b0 || bus.o_rd_wen !== 1'b0) begin
          fails++;
          $display("FAIL rnd%0d_bubble got ret=%b wen=%b exp 0/0", n, bus.o_retire, bus.o_rd_wen);
        end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_loads();
    test_jal_rd0();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
